// File: rtl/miner_pkg.sv
// Shared definitions for the miner host link: work-unit geometry, field
// offsets inside the 416-bit work word, and the UART receive state type.
package miner_pkg;

  localparam int WORK_BITS    = 416;
  localparam int WORK_BYTES   = 52;

  localparam int TARGET_MSB   = 415;
  localparam int NONCE_MSB    = 383;
  localparam int TAIL_MSB     = 351;
  localparam int MIDSTATE_MSB = 255;

  // Receive byte FSM states; kept here so checkers can decode the state.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Clock cycles per bit period (integer floor).
  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF input synchroniser followed by a
// start/data/stop FSM. Produces one-cycle byte_valid or byte_err strobes.
//
// Handshake: byte_valid and byte_err are single-cycle strobes with no
// back-pressure; byte_data is stable in the cycle byte_valid is high.
// The state register `state` is a plain rx_state_e so it can be probed.
module uart_rx_byte #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RxD,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);
  import miner_pkg::*;

  localparam int DIV   = bit_period(comm_clk_frequency, baud_rate);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_byte: bit period must be at least 4 clocks");
  end

  logic            rxd_meta;
  logic            rxd_sync;
  rx_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            armed;   // line has been seen high since the last error

  // Two-stage synchroniser; idle level is high so it resets to 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_sync <= rxd_meta;
    end
  end

  // Receive FSM. The IDLE cycle that sees the start edge counts as the
  // first cycle of the half-bit wait, so the start check lands HALF cycles
  // after the synchronised edge and data samples fall mid-bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rxd_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= RX_START;
            cnt   <= CNT_W'(1);
          end
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxd_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              byte_err <= 1'b1;
              armed    <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_work_receive.sv
// Host-link receive path: collects 52 UART bytes into one 416-bit work
// unit and presents it to the hashing core with a one-cycle work_valid.
// Partial frames are dropped on a bad stop bit or after an idle timeout.
//
// Handshake: work_valid is a single-cycle strobe with no back-pressure; the
// work outputs change only in the cycle work_valid is high and then hold.
module serial_work_receive #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200,
  parameter int idle_timeout_bits  = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         RxD,
  output logic         work_valid,
  output logic [31:0]  target,
  output logic [31:0]  nonce_start,
  output logic [95:0]  header_tail,
  output logic [255:0] midstate,
  output logic         frame_error,
  output logic         busy
);
  import miner_pkg::*;

  localparam int DIV     = bit_period(comm_clk_frequency, baud_rate);
  localparam int TIMEOUT = idle_timeout_bits * DIV;
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  logic [7:0]           byte_data;
  logic                 byte_valid;
  logic                 byte_err;
  logic [5:0]           byte_cnt;
  logic [WORK_BITS-1:0] shift_reg;
  logic [WORK_BITS-1:0] work_q;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 timeout_hit;

  uart_rx_byte #(
    .comm_clk_frequency(comm_clk_frequency),
    .baud_rate         (baud_rate)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .RxD       (RxD),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  // idle_cnt is loaded with 1 by the byte strobe itself, so it equals the
  // number of cycles since byte_valid; the next cycle would reach TIMEOUT.
  assign timeout_hit = (byte_cnt != 6'd0) && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  // Assembler, idle timer and output register. An arriving byte takes
  // priority over an expiring timeout; error and timeout share one pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_cnt    <= '0;
      shift_reg   <= '0;
      work_q      <= '0;
      idle_cnt    <= '0;
      work_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      work_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= (byte_cnt != 6'd0);
      if (byte_valid) begin
        shift_reg <= {shift_reg[WORK_BITS-9:0], byte_data};
        idle_cnt  <= IDLE_W'(1);
        if (byte_cnt == 6'(WORK_BYTES - 1)) begin
          work_q     <= {shift_reg[WORK_BITS-9:0], byte_data};
          work_valid <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          byte_cnt <= byte_cnt + 6'd1;
        end
      end else if (byte_err || timeout_hit) begin
        frame_error <= 1'b1;
        byte_cnt    <= '0;
        idle_cnt    <= '0;
      end else if (byte_cnt != 6'd0) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign target      = work_q[TARGET_MSB -: 32];
  assign nonce_start = work_q[NONCE_MSB -: 32];
  assign header_tail = work_q[TAIL_MSB -: 96];
  assign midstate    = work_q[MIDSTATE_MSB -: 256];

endmodule

// File: tb/tb_serial_work_receive.sv
// Bench for serial_work_receive at 1 MHz / 115200 baud (8 clocks per bit).
module tb_serial_work_receive;
  import miner_pkg::*;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 115_200;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int HALF    = DIV / 2;
  localparam int BV_LAT  = 2 + HALF + 9 * DIV;  // start cycle -> byte_valid visible
  localparam int TIMEOUT = 64 * DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic RxD = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         work_valid;
  logic [31:0]  target;
  logic [31:0]  nonce_start;
  logic [95:0]  header_tail;
  logic [255:0] midstate;
  logic         frame_error;
  logic         busy;

  serial_work_receive #(
    .comm_clk_frequency(CLK_HZ),
    .baud_rate         (BAUD),
    .idle_timeout_bits (64)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RxD        (RxD),
    .work_valid (work_valid),
    .target     (target),
    .nonce_start(nonce_start),
    .header_tail(header_tail),
    .midstate   (midstate),
    .frame_error(frame_error),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Line events announced by the driver, keyed by the cycle in which the
  // receiver's byte strobe (or error strobe) is due.
  logic [7:0] ev_byte [int];
  bit         ev_err  [int];
  int         last_start;

  // Observations used by the directed checks.
  int wv_seen = 0;
  int fe_seen = 0;
  int fe_last = 0;

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit good_stop);
    last_start = cyc;
    if (good_stop) ev_byte[cyc + BV_LAT] = d;
    else           ev_err[cyc + BV_LAT]  = 1'b1;
    RxD = 1'b0;
    idle(DIV);
    for (int b = 0; b < 8; b++) begin
      RxD = d[b];
      idle(DIV);
    end
    RxD = good_stop;
    idle(DIV);
  endtask

  task automatic send_bytes(input logic [415:0] u, input int count);
    for (int i = 0; i < count; i++) send_byte(u[415 - 8*i -: 8], 1'b1);
  endtask

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  // Bytes of the frame in progress; a full queue becomes the expected unit.
  initial begin : monitor
    logic [7:0]   frame_q[$];
    logic [415:0] exp_q[$];
    logic [415:0] exp_work;
    logic         exp_wv, exp_fe, exp_busy;
    logic         nxt_wv, nxt_fe, nxt_busy;
    logic [415:0] unit;
    int           last_bv;
    bit           rst_seen;
    exp_work = '0; exp_wv = 0; exp_fe = 0; exp_busy = 0;
    last_bv = 0; rst_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        n_cmp++;
        if ({work_valid, frame_error, busy} !== {exp_wv, exp_fe, exp_busy}) begin
          n_bad++;
          $display("FAIL ctrl cyc=%0d wv/fe/busy got=%b%b%b exp=%b%b%b",
                   cyc, work_valid, frame_error, busy, exp_wv, exp_fe, exp_busy);
        end
        n_cmp++;
        if ({target, nonce_start, header_tail, midstate} !== exp_work) begin
          n_bad++;
          $display("FAIL work cyc=%0d got=%h exp=%h", cyc,
                   {target, nonce_start, header_tail, midstate}, exp_work);
        end
        if (work_valid) wv_seen++;
        if (frame_error) begin
          fe_seen++;
          fe_last = cyc;
        end
      end
      // Expectations for the next cycle.
      if (!reset_n) begin
        frame_q.delete();
        nxt_wv = 0; nxt_fe = 0; nxt_busy = 0;
        exp_q.delete();
        exp_q.push_back('0);
        rst_seen = 1;
      end else begin
        nxt_wv = 0; nxt_fe = 0;
        nxt_busy = (frame_q.size() != 0);
        if (ev_byte.exists(cyc)) begin
          frame_q.push_back(ev_byte[cyc]);
          last_bv = cyc;
          if (frame_q.size() == WORK_BYTES) begin
            for (int i = 0; i < WORK_BYTES; i++) unit[415 - 8*i -: 8] = frame_q[i];
            exp_q.push_back(unit);
            nxt_wv = 1;
            frame_q.delete();
          end
        end else if (ev_err.exists(cyc)) begin
          nxt_fe = 1;
          frame_q.delete();
        end else if (frame_q.size() != 0 && (cyc + 1 - last_bv) == TIMEOUT) begin
          nxt_fe = 1;
          frame_q.delete();
        end
      end
      exp_wv = nxt_wv; exp_fe = nxt_fe; exp_busy = nxt_busy;
      if (exp_q.size() != 0) exp_work = exp_q.pop_front();
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [415:0] u1, u2, u3, u4;
    int           bv20;
    u1 = 416'h000007ff_55555540_4053081c_1a2b3c4d_5e6f7081_01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_c0ffee11_3e918f62;
    u2 = {u1[207:0], u1[415:208]} ^ {13{32'h5a5a_a5a5}};
    u3 = ~u1;
    u4 = u1 ^ {13{32'h1357_9bdf}};

    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(10);
    check_val("reset target", target, 32'h0);
    check_val("reset midstate", midstate[127:0], 128'h0);
    check_val("reset busy", busy, 1'b0);

    // Full unit.
    send_bytes(u1, WORK_BYTES);
    idle(4);
    check_val("u1 target", target, 32'h000007ff);
    check_val("u1 nonce", nonce_start, 32'h55555540);
    check_val("u1 tail", header_tail, 96'h4053081c_1a2b3c4d_5e6f7081);
    check_val("u1 midstate lo", midstate[31:0], 32'h3e918f62);
    check_val("u1 busy", busy, 1'b0);

    // Glitch: two-cycle low pulse.
    RxD = 1'b0;
    idle(2);
    RxD = 1'b1;
    idle(40);
    check_val("glitch busy", busy, 1'b0);
    check_val("glitch no error", fe_seen, 0);

    // Framing error on byte 10, then a clean unit.
    send_bytes(u3, 9);
    send_byte(u3[415 - 8*9 -: 8], 1'b0);
    RxD = 1'b1;
    idle(3 * DIV);
    check_val("ferr busy", busy, 1'b0);
    check_val("ferr count", fe_seen, 1);
    check_val("ferr target held", target, 32'h000007ff);
    send_bytes(u3, WORK_BYTES);
    idle(4);
    check_val("u3 target", target, u3[415:384]);

    // Timeout after 20 bytes.
    send_bytes(u1, 20);
    bv20 = last_start + BV_LAT;
    idle(TIMEOUT + 50);
    check_val("timeout delay", fe_last - bv20, 512);
    check_val("timeout busy", busy, 1'b0);
    check_val("timeout count", fe_seen, 2);
    check_val("timeout no unit", wv_seen, 2);

    // Two units back-to-back.
    send_bytes(u2, WORK_BYTES);
    send_bytes(u4, WORK_BYTES);
    idle(4);
    check_val("b2b units", wv_seen, 4);
    check_val("u4 midstate hi", midstate[255:128], u4[255:128]);

    // Reset after 30 bytes, then a full unit.
    send_bytes(u2, 30);
    idle(2);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(2);
    check_val("rst target", target, 32'h0);
    check_val("rst tail", header_tail, 96'h0);
    check_val("rst busy", busy, 1'b0);
    send_bytes(u1, WORK_BYTES);
    idle(4);
    check_val("post-rst target", target, 32'h000007ff);
    check_val("post-rst midstate lo", midstate[31:0], 32'h3e918f62);
    check_val("total units", wv_seen, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Run-time bound.
  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1);
  end

endmodule

// File: doc/serial_work_receive.md
# serial_work_receive

Receive side of the miner's host link. Deserialises the 8N1 UART stream on `RxD` and assembles 52 consecutive bytes into one 416-bit work unit: target, start nonce, header tail and midstate. Hands the unit to the hashing core with a single-cycle strobe. Sits between the `RxD` pin and the core's work/nonce load logic; it is the counterpart of `serial_transmit`.

## Interface
- `comm_clk_frequency`, 50_000_000: `clk` frequency in Hz.
- `baud_rate`, 115_200: line rate in bits per second.
- `idle_timeout_bits`, 64: inter-byte gap, in bit periods, after which a partial frame is discarded.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  synchronous, active-low reset.
- `RxD`  in  1  asynchronous serial input, idle high.
- `work_valid`  out  1  one-cycle strobe: a complete work unit is on the work outputs.
- `target`  out  32  work[415:384].
- `nonce_start`  out  32  work[383:352].
- `header_tail`  out  96  work[351:256].
- `midstate`  out  256  work[255:0].
- `frame_error`  out  1  one-cycle strobe: byte discarded (bad stop bit) or partial frame timed out.
- `busy`  out  1  high while a partial frame is held (byte count != 0).

## Operation
- Clock and reset: one clock `clk`; `reset_n` is synchronous and active-low.
- Bit period: DIV = comm_clk_frequency / baud_rate, integer floor; HALF = DIV/2. DIV below 4 is a configuration error, flagged by an elaboration-time check.
- Input sync: `RxD` passes through a 2-FF synchroniser, which resets to 1. All decisions use the synchronised value.
- RX byte FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START when the synchronised line is low.
  - START waits HALF cycles. Line still low -> DATA. Line high -> IDLE (glitch; no error).
  - DATA samples 8 bits, one every DIV cycles, LSB first.
  - STOP samples after DIV more cycles:
    - Sample high -> byte_valid pulse, then IDLE.
    - Sample low -> framing error, then IDLE. The FSM does not re-enter START until the line has been seen high.
- Assembler:
  - 6-bit byte counter, range 0..51. 416-bit shift register, shifted left by 8 on each byte_valid. The first byte received becomes work[415:408].
  - On the byte with counter = 51: copy the shift register (including that byte) to the output registers, pulse `work_valid`, clear the counter to 0.
  - A byte arriving after a completed unit starts a new frame. There is no overflow.
- Framing error:
  - `frame_error` pulses.
  - The counter clears to 0 and any partial frame is dropped.
  - The output registers keep the last good unit.
- Timeout:
  - The idle counter counts cycles since the last byte_valid, only while counter != 0.
  - When it reaches idle_timeout_bits*DIV: counter clears, `frame_error` pulses.
  - While counter == 0 the idle counter is held at 0.
- Reset values, mid-operation included: all outputs 0, FSM in IDLE, counters 0, shift register 0. A byte in flight when reset is asserted is lost.

## Timing
- The start edge is recognised 2 cycles after the pin falls (synchroniser).
- byte_valid asserts in the cycle after the stop-bit sample. That sample is 2 + HALF + 9*DIV cycles after the pin falls.
- `work_valid` and the updated outputs appear 1 cycle after the 52nd byte_valid. The outputs are registered and stable until the next `work_valid`.
- A framing error and a timeout expiring in the same cycle produce a single `frame_error` pulse.
- byte_valid in the same cycle the timeout expires: the byte wins. Its arrival resets the timeout, so no error and it is appended.
- `busy` is registered and follows the counter with 1-cycle latency.

## Structure
- Shared package `miner_pkg`:
  - WORK_BITS = 416, WORK_BYTES = 52.
  - Field offsets TARGET_MSB = 415, NONCE_MSB = 383, TAIL_MSB = 351, MIDSTATE_MSB = 255.
  - Shared with the core and the test benches.
- One sub-module, `uart_rx_byte`: the synchroniser plus RX FSM, giving `byte_data[7:0]`, `byte_valid` and `byte_err`. Its parameters are `comm_clk_frequency` and `baud_rate`.
- The top level holds the assembler, timeout counter and output registers.

## Test plan
All scenarios use comm_clk_frequency = 1_000_000 and baud_rate = 115_200, so DIV = 8.
- Full unit: 52 bytes of 416'h000007ff555555404053081c…3e918f62 sent back-to-back through `serial_transmit`. Expect one `work_valid`, `target` = 32'h000007ff, `nonce_start` = 32'h55555540, midstate[31:0] = 32'h3e918f62, `busy` low afterwards.
- Glitch rejection: `RxD` pulsed low for 2 cycles. Expect no byte, no `frame_error`, counter 0.
- Framing error: byte 10 of a frame sent with its stop bit low. Expect a `frame_error` pulse and `busy` = 0. A following clean 52-byte unit is delivered correctly.
- Timeout: 20 bytes sent, then a gap longer than 64*8 cycles. Expect a `frame_error` pulse at exactly 512 cycles after the 20th byte_valid, `busy` = 0, and no `work_valid`.
- Back-to-back: two different units with no gap between them. Expect two `work_valid` strobes, each unit's outputs correct, and the first unit's outputs held until the second strobe.
- Reset mid-frame: `reset_n` low for 1 cycle after 30 bytes. Expect all outputs 0. A following full unit is delivered correctly.
